cam_config_seq: RTL and testbench



---
 rtl/cam_cfg_pkg.sv | 28 ++
 rtl/cam_rom.sv | 63 ++++++
 rtl/cam_config_seq.sv | 137 +++++++++++++
 tb/tb_cam_config_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg
//   Shared constants and types for the OV7670 boot-time register loader:
//   table marker words, the default SCCB write address and the sequencer
//   state encoding.
package cam_cfg_pkg;

  // Table marker words. Neither value is a real OV7670 register write.
  localparam logic [15:0] ROM_END   = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY = 16'hFFF0;

  // OV7670 SCCB write address. The I2C master consumes it.
  localparam logic [7:0]  CAM_I2C_ADDR = 8'h42;

  // Last table index. The sequencer stops here instead of wrapping to 0.
  localparam logic [7:0]  ROM_LAST_ADDR = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_DONE
  } cfg_state_t;

endpackage

// File: rtl/cam_rom.sv
// cam_rom
//   256x16 OV7670 init table with a one-clock registered read.
//   Each entry holds {reg_addr[15:8], reg_val[7:0]}. Two entries are markers:
//   16'hFFF0 requests a 10 ms pause, and 16'hFFFF ends the table.
//   Unused entries read as 16'hFFFF.
// Ports
//   i_clk   in   1   system clock
//   i_rstn  in   1   asynchronous active-low reset; clears o_dout
//   i_addr  in   8   table index
//   o_dout  out  16  table word for the index sampled on the previous clock
module cam_rom
  import cam_cfg_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_addr,
  output logic [15:0] o_dout
);

  function automatic logic [15:0] init_word(input logic [7:0] idx);
    case (idx)
      8'd0:    return 16'h1280;  // COM7: soft reset
      8'd1:    return ROM_DELAY; // let the sensor come out of reset
      8'd2:    return 16'h1214;  // COM7: QVGA, RGB output
      8'd3:    return 16'h40D0;  // COM15: RGB565, full range
      8'd4:    return 16'h3A04;  // TSLB
      8'd5:    return 16'h1100;  // CLKRC: no prescale
      8'd6:    return 16'h0C04;  // COM3: enable scaling
      8'd7:    return 16'h3E19;  // COM14: PCLK divide for QVGA
      8'd8:    return 16'h7032;  // SCALING_XSC
      8'd9:    return 16'h7135;  // SCALING_YSC
      8'd10:   return 16'h7211;  // SCALING_DCWCTR
      8'd11:   return 16'h73F1;  // SCALING_PCLK_DIV
      8'd12:   return 16'hA202;  // SCALING_PCLK_DELAY
      8'd13:   return 16'h8C00;  // RGB444 off
      8'd14:   return 16'h1713;  // HSTART
      8'd15:   return 16'h1801;  // HSTOP
      8'd16:   return 16'h32B6;  // HREF
      8'd17:   return 16'h1902;  // VSTART
      8'd18:   return 16'h1A7A;  // VSTOP
      8'd19:   return 16'h030A;  // VREF
      8'd20:   return 16'h1E07;  // MVFP
      default: return ROM_END;
    endcase
  endfunction

  logic [15:0] rom_tbl [256];

  always_comb begin
    for (int i = 0; i < 256; i++) begin
      rom_tbl[i] = init_word(8'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_dout <= '0;
    end else begin
      o_dout <= rom_tbl[i_addr];
    end
  end

endmodule

// File: rtl/cam_config_seq.sv
// cam_config_seq
//   Boot-time OV7670 register loader. A start pulse makes the block walk the
//   cam_rom table from index 0. It issues one I2C register write per entry,
//   pauses on delay markers and stops on the end marker. It then holds
//   o_config_done high until the next start pulse.
// Ports
//   i_clk           in   1   system clock
//   i_rstn          in   1   asynchronous active-low reset; aborts any sequence
//   i_i2c_ready     in   1   I2C master idle; drops low while a write runs
//   i_config_start  in   1   1-cycle pulse; honoured only in IDLE or DONE
//   i_rom_data      in   16  table word {reg_addr, reg_val}, 1-clock latency
//   o_rom_addr      out  8   table index presented to cam_rom
//   o_i2c_start     out  1   1-cycle write request to the I2C master
//   o_i2c_addr      out  8   camera register sub-address
//   o_i2c_data      out  8   register value
//   o_config_done   out  1   high once the end of the table is reached
module cam_config_seq
  import cam_cfg_pkg::*;
#(
  parameter int         CLK_F        = 27_000_000,
  parameter logic [7:0] CAM_I2C_ADDR = cam_cfg_pkg::CAM_I2C_ADDR
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_i2c_ready,
  input  logic        i_config_start,
  input  logic [15:0] i_rom_data,
  output logic [7:0]  o_rom_addr,
  output logic        o_i2c_start,
  output logic [7:0]  o_i2c_addr,
  output logic [7:0]  o_i2c_data,
  output logic        o_config_done
);

  // Delay marker length: 10 ms worth of clocks.
  localparam int DLY_CYCLES = (CLK_F / 100 > 1) ? CLK_F / 100 : 2;
  localparam int DLY_W      = $clog2(DLY_CYCLES);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY_CYCLES - 1);

  // The SCCB address belongs to the I2C master. It is carried here only so
  // that both blocks are parameterised from one place.
  logic [7:0] unused_cam_addr;
  assign unused_cam_addr = CAM_I2C_ADDR;

  cfg_state_t       state_reg, state_next;
  logic [7:0]       rom_addr_reg, rom_addr_next;
  logic [DLY_W-1:0] dly_cnt_reg, dly_cnt_next;
  logic [7:0]       i2c_addr_reg, i2c_addr_next;
  logic [7:0]       i2c_data_reg, i2c_data_next;
  logic             i2c_start_reg, i2c_start_next;
  logic             done_reg, done_next;

  logic last_entry;
  logic dly_last;
  assign last_entry = (rom_addr_reg == ROM_LAST_ADDR);
  assign dly_last   = (dly_cnt_reg == DLY_LAST);

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg     <= ST_IDLE;
      rom_addr_reg  <= '0;
      dly_cnt_reg   <= '0;
      i2c_addr_reg  <= '0;
      i2c_data_reg  <= '0;
      i2c_start_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rom_addr_reg  <= rom_addr_next;
      dly_cnt_reg   <= dly_cnt_next;
      i2c_addr_reg  <= i2c_addr_next;
      i2c_data_reg  <= i2c_data_next;
      i2c_start_reg <= i2c_start_next;
      done_reg      <= done_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (i_config_start) state_next = ST_FETCH;
      ST_FETCH:         state_next = ST_DECODE;
      ST_DECODE: begin
        if (i_rom_data == ROM_END)        state_next = ST_DONE;
        else if (i_rom_data == ROM_DELAY) state_next = ST_DELAY;
        else                              state_next = ST_SEND;
      end
      ST_SEND:      if (i_i2c_ready)  state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!i_i2c_ready) state_next = ST_WAIT_DONE;
      // The last index finishes the sequence instead of wrapping to 0.
      ST_WAIT_DONE: if (i_i2c_ready) state_next = last_entry ? ST_DONE : ST_FETCH;
      ST_DELAY:     if (dly_last)    state_next = last_entry ? ST_DONE : ST_FETCH;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Output and datapath logic. All outputs are registered. The write request
  // therefore appears in the first WAIT_BUSY cycle, after addr/data have
  // already been stable for one clock.
  always_comb begin
    rom_addr_next  = rom_addr_reg;
    dly_cnt_next   = dly_cnt_reg;
    i2c_addr_next  = i2c_addr_reg;
    i2c_data_next  = i2c_data_reg;
    i2c_start_next = 1'b0;
    done_next      = (state_next == ST_DONE);
    case (state_reg)
      ST_IDLE, ST_DONE: if (i_config_start) rom_addr_next = '0;
      ST_DECODE: begin
        if (i_rom_data == ROM_DELAY) begin
          dly_cnt_next = '0;
        end else if (i_rom_data != ROM_END) begin
          i2c_addr_next = i_rom_data[15:8];
          i2c_data_next = i_rom_data[7:0];
        end
      end
      ST_SEND: if (i_i2c_ready) i2c_start_next = 1'b1;
      ST_WAIT_DONE: begin
        if (i_i2c_ready && !last_entry) rom_addr_next = rom_addr_reg + 8'd1;
      end
      ST_DELAY: begin
        dly_cnt_next = dly_cnt_reg + DLY_W'(1);
        if (dly_last && !last_entry) rom_addr_next = rom_addr_reg + 8'd1;
      end
      default: ;
    endcase
  end

  assign o_rom_addr    = rom_addr_reg;
  assign o_i2c_start   = i2c_start_reg;
  assign o_i2c_addr    = i2c_addr_reg;
  assign o_i2c_data    = i2c_data_reg;
  assign o_config_done = done_reg;

endmodule

// File: tb/tb_cam_config_seq.sv
// tb_cam_config_seq
//   Bench for cam_config_seq wired to cam_rom. The bench keeps its own copy
//   of the init table. Expected register writes go into a scoreboard queue
//   when a start pulse is driven. Each o_i2c_start pulse pops one entry and
//   compares it with the write the DUT issues.
module tb_cam_config_seq;

  localparam int CLK_F = 1_000_000;
  localparam int DLY   = CLK_F / 100;
  localparam int TBL_N = 22;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        man_ready = 1'b1;
  logic        resp_ready = 1'b1;
  logic        auto_resp = 1'b0;
  logic        i2c_ready;
  logic [15:0] rom_data;
  logic [7:0]  rom_addr;
  logic        i2c_start;
  logic [7:0]  i2c_addr;
  logic [7:0]  i2c_data;
  logic        cfg_done;

  assign i2c_ready = auto_resp ? resp_ready : man_ready;

  always #5 clk = ~clk;

  cam_rom u_rom (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .i_addr (rom_addr),
    .o_dout (rom_data)
  );

  cam_config_seq #(.CLK_F(CLK_F)) u_dut (
    .i_clk          (clk),
    .i_rstn         (rst_n),
    .i_i2c_ready    (i2c_ready),
    .i_config_start (cfg_start),
    .i_rom_data     (rom_data),
    .o_rom_addr     (rom_addr),
    .o_i2c_start    (i2c_start),
    .o_i2c_addr     (i2c_addr),
    .o_i2c_data     (i2c_data),
    .o_config_done  (cfg_done)
  );

  logic [15:0] ref_tbl [TBL_N] = '{
    16'h1280, 16'hFFF0, 16'h1214, 16'h40D0, 16'h3A04, 16'h1100,
    16'h0C04, 16'h3E19, 16'h7032, 16'h7135, 16'h7211, 16'h73F1,
    16'hA202, 16'h8C00, 16'h1713, 16'h1801, 16'h32B6, 16'h1902,
    16'h1A7A, 16'h030A, 16'h1E07, 16'hFFFF
  };

  logic [15:0] sb [$];
  logic [15:0] mon_exp;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_pulses = 0;
  int run_writes = 0;
  int first_cyc = 0;
  int last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Push the writes the table should produce and report where it ends.
  task automatic push_run(output int n_wr, output int end_idx);
    n_wr = 0;
    end_idx = 255;
    for (int i = 0; i < TBL_N; i++) begin
      if (ref_tbl[i] == 16'hFFFF) begin
        end_idx = i;
        break;
      end
      if (ref_tbl[i] != 16'hFFF0) begin
        sb.push_back(ref_tbl[i]);
        n_wr++;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (!cfg_done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", cfg_done, 1);
  endtask

  task automatic wait_writes(input int target, input int max_cyc);
    int n = 0;
    while (run_writes < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("write_seen", run_writes >= target, 1);
  endtask

  // Write monitor and scoreboard consumer.
  initial forever begin
    @(negedge clk);
    if (i2c_start) begin
      if (n_pulses > 0) check("start_gap_ge4", (cyc - last_cyc) >= 4, 1);
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        $display("wr %0d @%0d addr=%02h data=%02h exp=%04h",
                 run_writes, cyc, i2c_addr, i2c_data, mon_exp);
        check("wr_addr", i2c_addr, mon_exp[15:8]);
        check("wr_data", i2c_data, mon_exp[7:0]);
      end
      // The second table entry is the 10 ms delay marker.
      if (run_writes == 1) begin
        check("dly_gap_min", (cyc - first_cyc) >= DLY, 1);
        check("dly_gap_max", (cyc - first_cyc) <= DLY + 40, 1);
      end
      if (run_writes == 0) first_cyc = cyc;
      run_writes++;
      n_pulses++;
      last_cyc = cyc;
    end
  end

  // I2C responder: ready drops 5 clocks after each start, for 3 clocks.
  initial forever begin
    @(negedge clk);
    if (auto_resp && i2c_start) begin
      repeat (5) @(negedge clk);
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      resp_ready = 1'b1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_wr;
    int end_idx;
    int n;

    // Reset with the master idle and no start.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_pulses", n_pulses, 0);
    check("rst_done", cfg_done, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_i2c_addr", i2c_addr, 0);
    check("rst_i2c_data", i2c_data, 0);

    // First write under manual control of ready.
    run_writes = 0;
    sb.push_back(ref_tbl[0]);
    pulse_start();
    wait_writes(1, 50);
    repeat (30) @(negedge clk);
    check("hold_no_2nd", n_pulses, 1);
    man_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_no_2nd", n_pulses, 1);
    check("held_addr", i2c_addr, {24'd0, ref_tbl[0][15:8]});
    check("held_data", i2c_data, {24'd0, ref_tbl[0][7:0]});

    // Abort mid-WAIT_DONE: outputs drop at once.
    #2 rst_n = 1'b0;
    #1;
    check("abort_rom_addr", rom_addr, 0);
    check("abort_start", i2c_start, 0);
    check("abort_i2c_addr", i2c_addr, 0);
    check("abort_i2c_data", i2c_data, 0);
    check("abort_done", cfg_done, 0);
    check("abort_sb_empty", sb.size(), 0);
    @(negedge clk);
    man_ready = 1'b1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Full run with the automatic responder. A start during DELAY is ignored.
    auto_resp = 1'b1;
    run_writes = 0;
    push_run(n_wr, end_idx);
    pulse_start();
    check("run_start_addr", rom_addr, 0);
    wait_writes(1, 50);
    repeat (5000) @(negedge clk);
    check("dly_rom_addr", rom_addr, 1);
    check("dly_pulses", run_writes, 1);
    pulse_start();
    wait_done(DLY + 2000);
    check("run_writes", run_writes, n_wr);
    check("run_sb_empty", sb.size(), 0);
    check("run_end_addr", rom_addr, end_idx);
    n = n_pulses;
    repeat (20) @(negedge clk);
    check("done_held", cfg_done, 1);
    check("done_quiet", n_pulses, n);

    // Restart from DONE.
    run_writes = 0;
    push_run(n_wr, end_idx);
    pulse_start();
    check("restart_done_clr", cfg_done, 0);
    wait_done(DLY + 2000);
    check("rerun_writes", run_writes, n_wr);
    check("rerun_sb_empty", sb.size(), 0);
    check("rerun_end_addr", rom_addr, end_idx);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
